// File: rtl/wr_recovery_pkg.sv
// Shared types for the write-path recovery controller.
// The state encoding is also the debug value on state_o.
package wr_recovery_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        SLV_RST  = 2'd2,
        WAIT_CLR = 2'd3
    } recovery_state_e;

    function automatic logic [StateW-1:0] state_code(
        input recovery_state_e s
    );
        return s;
    endfunction

endpackage

// File: rtl/wr_recovery_timer.sv
// Loadable up-counter that holds at its terminal count.
// tc_o flags that the terminal value has been reached.
module wr_recovery_timer #(
    parameter int unsigned Terminal = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W =
        (Terminal < 1) ? 1 : $clog2(Terminal + 1);
    localparam logic [W-1:0] Tc = W'(Terminal);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Tc)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Tc);

endmodule

// File: rtl/wr_recovery_ctrl.sv
// Write-path fault recovery sequencer: isolate, drain,
// reset the slave, then hold until software clears the IRQ.
module wr_recovery_ctrl
    import wr_recovery_pkg::*;
#(
    parameter int unsigned DrainCycles   = 64,
    parameter int unsigned CntWidth      = 8,
    parameter int unsigned RstAckTimeout = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reset_req_i,
    input  logic                timeout_i,
    input  logic                w_inflight_i,
    input  logic                slv_rst_ack_i,
    input  logic                irq_clear_i,
    output logic                block_aw_o,
    output logic                block_w_o,
    output logic                slv_rst_req_o,
    output logic                irq_o,
    output logic                cause_timeout_o,
    output logic                overrun_o,
    output logic                ack_timeout_o,
    output logic [CntWidth-1:0] recovery_cnt_o,
    output logic                busy_o,
    output logic [1:0]          state_o
);

    if (DrainCycles < 1) begin : g_bad_drain
        $error("DrainCycles must be >= 1");
    end
    if (RstAckTimeout < 1) begin : g_bad_ack
        $error("RstAckTimeout must be >= 1");
    end
    if (CntWidth < 1) begin : g_bad_cnt
        $error("CntWidth must be >= 1");
    end

    recovery_state_e state_q, state_d;

    logic drain_tc;
    logic ack_tc;

    logic baw_q, baw_d;
    logic bw_q, bw_d;
    logic srr_q, srr_d;
    logic irq_q, irq_d;
    logic busy_q, busy_d;
    logic cause_q, cause_d;
    logic ovr_q, ovr_d;
    logic ackto_q, ackto_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    wr_recovery_timer #(
        .Terminal (DrainCycles - 1)
    ) u_drain_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (state_q != DRAIN),
        .en_i   (state_q == DRAIN),
        .tc_o   (drain_tc)
    );

    wr_recovery_timer #(
        .Terminal (RstAckTimeout - 1)
    ) u_ack_tmr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (state_q != SLV_RST),
        .en_i   (state_q == SLV_RST),
        .tc_o   (ack_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baw_q   <= 1'b0;
            bw_q    <= 1'b0;
            srr_q   <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= 1'b0;
            ovr_q   <= 1'b0;
            ackto_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            baw_q   <= baw_d;
            bw_q    <= bw_d;
            srr_q   <= srr_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            ovr_q   <= ovr_d;
            ackto_q <= ackto_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (reset_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!w_inflight_i || drain_tc) begin
                    state_d = SLV_RST;
                end
            end
            SLV_RST: begin
                if (slv_rst_ack_i || ack_tc) begin
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (irq_clear_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they
    // switch on the same edge as the state itself.
    always_comb begin
        baw_d   = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        bw_d    = (state_d == SLV_RST) ||
                  (state_d == WAIT_CLR);
        srr_d   = (state_d == SLV_RST);
        irq_d   = (state_d == WAIT_CLR);
        cause_d = cause_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        ackto_d = ackto_q;

        if ((state_q == IDLE) && reset_req_i) begin
            cause_d = timeout_i;
            if (!(&cnt_q)) cnt_d = cnt_q + CntWidth'(1);
        end
        if ((state_q == SLV_RST) && !slv_rst_ack_i
            && ack_tc) begin
            ackto_d = 1'b1;
        end
        if ((state_q == WAIT_CLR) && irq_clear_i) begin
            ovr_d   = 1'b0;
            ackto_d = 1'b0;
        end
        // A late fault is recorded even when it races the clear.
        if ((state_q != IDLE) && reset_req_i) begin
            ovr_d = 1'b1;
        end
    end

    assign block_aw_o      = baw_q;
    assign block_w_o       = bw_q;
    assign slv_rst_req_o   = srr_q;
    assign irq_o           = irq_q;
    assign busy_o          = busy_q;
    assign cause_timeout_o = cause_q;
    assign overrun_o       = ovr_q;
    assign ack_timeout_o   = ackto_q;
    assign recovery_cnt_o  = cnt_q;
    assign state_o         = state_code(state_q);

endmodule

// File: tb/tb_wr_recovery_ctrl.sv
// Directed and random checks of wr_recovery_ctrl against
// a phase/age reference model.
module tb_wr_recovery_ctrl;

    localparam int DC = 4;
    localparam int AT = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req = 1'b0;
    logic to = 1'b0;
    logic winf = 1'b0;
    logic ack = 1'b0;
    logic clr = 1'b0;

    logic block_aw, block_w, srr, irq;
    logic cause, ovr, ackto, busy;
    logic [CW-1:0] cnt;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail = 0;

    int m_st, m_age, m_cnt;
    bit m_cause, m_ovr, m_ackto;
    logic [CW-1:0] saved_cnt;

    wr_recovery_ctrl #(
        .DrainCycles   (DC),
        .CntWidth      (CW),
        .RstAckTimeout (AT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .reset_req_i     (req),
        .timeout_i       (to),
        .w_inflight_i    (winf),
        .slv_rst_ack_i   (ack),
        .irq_clear_i     (clr),
        .block_aw_o      (block_aw),
        .block_w_o       (block_w),
        .slv_rst_req_o   (srr),
        .irq_o           (irq),
        .cause_timeout_o (cause),
        .overrun_o       (ovr),
        .ack_timeout_o   (ackto),
        .recovery_cnt_o  (cnt),
        .busy_o          (busy),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {block_aw, block_w, srr, irq, cause, ovr,
                ackto, cnt, busy, state};
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [1:0] s;
        logic [CW-1:0] c;
        s = 2'(m_st);
        c = CW'(m_cnt);
        return {s != 2'd0, s >= 2'd2, s == 2'd2, s == 2'd3,
                m_cause, m_ovr, m_ackto, c, s != 2'd0, s};
    endfunction

    task automatic model_reset();
        m_st = 0; m_age = 0; m_cnt = 0;
        m_cause = 0; m_ovr = 0; m_ackto = 0;
    endtask

    // Phases: 0 idle, 1 drain, 2 slave reset, 3 wait clear.
    task automatic model_step();
        case (m_st)
            0: if (req) begin
                m_st = 1; m_age = 0; m_cause = to;
                if (m_cnt < CMAX) m_cnt++;
            end
            1: begin
                if (req) m_ovr = 1;
                if (!winf || m_age == DC - 1) begin
                    m_st = 2; m_age = 0;
                end else m_age++;
            end
            2: begin
                if (req) m_ovr = 1;
                if (ack) begin
                    m_st = 3; m_age = 0;
                end else if (m_age == AT - 1) begin
                    m_ackto = 1; m_st = 3; m_age = 0;
                end else m_age++;
            end
            default: begin
                if (clr) begin
                    m_st = 0; m_ovr = 0; m_ackto = 0;
                end
                if (req) m_ovr = 1;
            end
        endcase
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag, 32'(obs_vec()), 32'(exp_vec()));
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec", 32'(obs_vec()), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fast path: nothing in flight, ack already high.
        ack = 1; winf = 0; to = 1; req = 1;
        tick("s1_c1");
        req = 0;
        check("s1_baw", 32'(block_aw), 32'(1));
        check("s1_st1", 32'(state), 32'(1));
        tick("s1_c2");
        check("s1_st2", 32'(state), 32'(2));
        tick("s1_c3");
        check("s1_st3", 32'(state), 32'(3));
        check("s1_irq", 32'(irq), 32'(1));
        check("s1_cause", 32'(cause), 32'(1));
        check("s1_cnt", 32'(cnt), 32'(1));
        clr = 1;
        tick("s1_clr");
        clr = 0;
        check("s1_idle", 32'(state), 32'(0));
        check("s1_blk", 32'({block_aw, block_w, irq}), 32'(0));

        // Drain runs to its limit, then ack never arrives.
        ack = 0; winf = 1; to = 0; req = 1;
        tick("s2_req");
        req = 0;
        for (int i = 0; i < DC; i++) begin
            check("s2_drain", 32'(state), 32'(1));
            check("s2_bw0", 32'(block_w), 32'(0));
            tick("s2_d");
        end
        check("s2_slv", 32'(state), 32'(2));
        check("s2_bw1", 32'(block_w), 32'(1));
        check("s2_cause", 32'(cause), 32'(0));
        for (int i = 0; i < AT; i++) begin
            check("s3_srr", 32'(srr), 32'(1));
            tick("s3_a");
        end
        check("s3_wait", 32'(state), 32'(3));
        check("s3_ackto", 32'(ackto), 32'(1));
        check("s3_srr0", 32'(srr), 32'(0));
        clr = 1;
        tick("s3_clr");
        clr = 0;
        check("s3_ackto0", 32'(ackto), 32'(0));

        // Overrun during slave reset, then a racing clear.
        winf = 0; ack = 0; req = 1;
        tick("s4_req");
        req = 0;
        tick("s4_drn");
        saved_cnt = cnt;
        req = 1;
        tick("s4_ovr");
        req = 0;
        check("s4_ovr1", 32'(ovr), 32'(1));
        check("s4_cnt", 32'(cnt), 32'(saved_cnt));
        check("s4_st", 32'(state), 32'(2));
        ack = 1;
        tick("s4_ack");
        clr = 1; req = 1;
        tick("s4_race");
        clr = 0;
        check("s4_race_st", 32'(state), 32'(0));
        check("s4_race_ovr", 32'(ovr), 32'(1));
        tick("s4_retake");
        req = 0;
        check("s4_retake_st", 32'(state), 32'(1));
        tick("s4_a");
        tick("s4_b");
        clr = 1;
        tick("s4_clr");
        clr = 0;

        // Async reset mid-cycle while in slave reset.
        ack = 0; req = 1;
        tick("s5_req");
        req = 0;
        tick("s5_drn");
        check("s5_slv", 32'(state), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("s5_rst_vec", 32'(obs_vec()), 32'(0));
        check("s5_rst_st", 32'(state), 32'(0));
        #3 rst_n = 1'b1;

        // Saturation of the recovery counter.
        ack = 1; winf = 0;
        for (int r = 0; r < 5; r++) begin
            to = 1'($urandom_range(0, 1));
            req = 1;
            tick("s6_req");
            req = 0;
            tick("s6_d");
            tick("s6_s");
            if (r == 0) check("s6_cnt1", 32'(cnt), 32'(1));
            clr = 1;
            tick("s6_clr");
            clr = 0;
        end
        check("s6_sat", 32'(cnt), 32'(CMAX));

        for (int i = 0; i < 3000; i++) begin
            req  = ($urandom_range(0, 9) == 0);
            to   = 1'($urandom_range(0, 1));
            winf = ($urandom_range(0, 2) != 0);
            ack  = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
